// File: rtl/trace_pkg.sv
// Shared types and default widths for the trace event collector and its FIFO.
package trace_pkg;

  typedef enum logic [1:0] {
    SRC_READ_REQ  = 2'd0,
    SRC_READ_CMP  = 2'd1,
    SRC_WRITE_REQ = 2'd2,
    SRC_THREAD    = 2'd3
  } trace_src_t;

  localparam int unsigned TRACE_NUM_SRC   = 4;
  localparam int unsigned TRACE_PAYLOAD_W = 64;
  localparam int unsigned TRACE_TS_W      = 32;
  localparam int unsigned TRACE_DEPTH     = 16;
  localparam int unsigned TRACE_DROP_W    = 16;
  localparam int unsigned TRACE_SRC_W     = $clog2(TRACE_NUM_SRC);

  typedef struct packed {
    logic [TRACE_TS_W-1:0]      ts;
    logic [TRACE_SRC_W-1:0]     src;
    logic [TRACE_PAYLOAD_W-1:0] payload;
  } trace_record_t;

endpackage

// File: rtl/trace_fifo.sv
// Circular-buffer FIFO of trace records; the head output keeps the last
// popped record while the FIFO is empty.
module trace_fifo
  import trace_pkg::*;
#(
  parameter type         T     = trace_record_t,
  parameter int unsigned DEPTH = TRACE_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  T                       i_data,
  input  logic                   i_pop,
  output T                       o_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  T              r_mem [DEPTH];
  T              r_last;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage is written before the read pointer can reach it, so it needs no reset.
  assign o_data = o_empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/trace_event_collector.sv
// Trace event front end: per-source timestamped capture, round-robin
// arbitration into a record FIFO, and a saturating drop counter.
module trace_event_collector
  import trace_pkg::*;
#(
  parameter int unsigned NUM_SRC   = TRACE_NUM_SRC,
  parameter int unsigned PAYLOAD_W = TRACE_PAYLOAD_W,
  parameter int unsigned TS_W      = TRACE_TS_W,
  parameter int unsigned DEPTH     = TRACE_DEPTH,
  parameter int unsigned DROP_W    = TRACE_DROP_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*PAYLOAD_W-1:0] src_payload,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [TS_W-1:0]              out_ts,
  output logic [$clog2(NUM_SRC)-1:0]   out_src,
  output logic [PAYLOAD_W-1:0]         out_payload,
  output logic [$clog2(DEPTH):0]       fill_level,
  output logic [DROP_W-1:0]            drop_count,
  input  logic                         clear_drops
);

  localparam int unsigned SRC_W  = $clog2(NUM_SRC);
  localparam int unsigned FILL_W = $clog2(DEPTH) + 1;
  localparam int unsigned DN_W   = $clog2(NUM_SRC + 1);
  localparam int unsigned SUM_W  = DROP_W + DN_W;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef struct packed {
    logic [TS_W-1:0]      ts;
    logic [SRC_W-1:0]     src;
    logic [PAYLOAD_W-1:0] payload;
  } rec_t;

  logic [TS_W-1:0]      r_ts_cnt;
  logic [NUM_SRC-1:0]   r_hold_v;
  logic [PAYLOAD_W-1:0] r_hold_pl [NUM_SRC];
  logic [TS_W-1:0]      r_hold_ts [NUM_SRC];
  logic [SRC_W-1:0]     r_rr_ptr;
  logic [DROP_W-1:0]    r_drop_cnt;

  logic                 w_full;
  logic                 w_empty;
  logic [FILL_W-1:0]    w_count;
  logic                 w_grant_v;
  logic [SRC_W-1:0]     w_grant;
  logic [SRC_W-1:0]     w_idx;
  logic [NUM_SRC-1:0]   w_gsel;
  logic [NUM_SRC-1:0]   w_take;
  logic [NUM_SRC-1:0]   w_drop;
  logic [DN_W-1:0]      w_drop_n;
  logic [SUM_W-1:0]     w_drop_sum;
  rec_t                 w_push_rec;
  rec_t                 w_head;

  // Round-robin scan from r_rr_ptr; a full FIFO blocks all grants even if
  // the head is being popped this cycle.
  always_comb begin
    w_grant_v = 1'b0;
    w_grant   = '0;
    w_idx     = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      w_idx = SRC_W'((32'(r_rr_ptr) + k) % NUM_SRC);
      if (!w_grant_v && !w_full && r_hold_v[w_idx]) begin
        w_grant_v = 1'b1;
        w_grant   = w_idx;
      end
    end
  end

  // A held source may only take a new event in the cycle its hold is granted away.
  always_comb begin
    w_gsel   = '0;
    w_take   = '0;
    w_drop   = '0;
    w_drop_n = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_gsel[i] = w_grant_v && (w_grant == SRC_W'(i));
      w_take[i] = src_valid[i] && (!r_hold_v[i] || w_gsel[i]);
      w_drop[i] = src_valid[i] && !w_take[i];
      w_drop_n  = w_drop_n + DN_W'(w_drop[i]);
    end
  end

  assign w_drop_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_drop_n);
  assign w_push_rec = '{ts: r_hold_ts[w_grant], src: w_grant, payload: r_hold_pl[w_grant]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_v <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        r_hold_pl[i] <= '0;
        r_hold_ts[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (w_take[i]) begin
          r_hold_v[i]  <= 1'b1;
          r_hold_pl[i] <= src_payload[i*PAYLOAD_W +: PAYLOAD_W];
          r_hold_ts[i] <= r_ts_cnt;
        end else if (w_gsel[i]) begin
          r_hold_v[i]  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts_cnt   <= '0;
      r_rr_ptr   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + TS_W'(1);
      if (w_grant_v) begin
        r_rr_ptr <= (w_grant == SRC_W'(NUM_SRC - 1)) ? '0 : w_grant + SRC_W'(1);
      end
      if (clear_drops) begin
        r_drop_cnt <= '0;
      end else if (w_drop_sum > SUM_W'(DROP_MAX)) begin
        r_drop_cnt <= DROP_MAX;
      end else begin
        r_drop_cnt <= DROP_W'(w_drop_sum);
      end
    end
  end

  trace_fifo #(
    .T     (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_grant_v),
    .i_data  (w_push_rec),
    .i_pop   (out_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign out_valid   = !w_empty;
  assign out_ts      = w_head.ts;
  assign out_src     = w_head.src;
  assign out_payload = w_head.payload;
  assign fill_level  = w_count;
  assign drop_count  = r_drop_cnt;

endmodule

// File: tb/tb_trace_event_collector.sv
// Bench for trace_event_collector: a default-width instance and a narrow
// (TS_W=4, DROP_W=2) instance share stimulus and one queue-based model.
module tb_trace_event_collector;

  localparam int NS  = 4;
  localparam int PW  = 64;
  localparam int DEP = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NS-1:0]   src_valid;
  logic [NS*PW-1:0] src_payload;
  logic            out_ready;
  logic            clear_drops;

  logic        a_valid, b_valid;
  logic [31:0] a_ts;
  logic [3:0]  b_ts;
  logic [1:0]  a_src, b_src;
  logic [63:0] a_pl, b_pl;
  logic [4:0]  a_fill, b_fill;
  logic [15:0] a_drop;
  logic [1:0]  b_drop;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trace_event_collector #(
    .NUM_SRC(NS), .PAYLOAD_W(PW), .TS_W(32), .DEPTH(DEP), .DROP_W(16)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_payload(src_payload),
    .out_valid(a_valid), .out_ready(out_ready), .out_ts(a_ts), .out_src(a_src),
    .out_payload(a_pl), .fill_level(a_fill), .drop_count(a_drop), .clear_drops(clear_drops)
  );

  trace_event_collector #(
    .NUM_SRC(NS), .PAYLOAD_W(PW), .TS_W(4), .DEPTH(DEP), .DROP_W(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_payload(src_payload),
    .out_valid(b_valid), .out_ready(out_ready), .out_ts(b_ts), .out_src(b_src),
    .out_payload(b_pl), .fill_level(b_fill), .drop_count(b_drop), .clear_drops(clear_drops)
  );

  typedef struct {
    logic [31:0] ts;
    int          src;
    logic [63:0] pl;
  } rec_t;

  rec_t        mq[$];
  rec_t        m_last;
  rec_t        popped[$];
  bit          m_hv[NS];
  logic [31:0] m_hts[NS];
  logic [63:0] m_hpl[NS];
  int          m_rr;
  logic [31:0] m_ts;
  int          da, db;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    mq.delete();
    m_last = '{ts: 32'd0, src: 0, pl: 64'd0};
    for (int i = 0; i < NS; i++) begin
      m_hv[i]  = 1'b0;
      m_hts[i] = '0;
      m_hpl[i] = '0;
    end
    m_rr = 0;
    m_ts = '0;
    da   = 0;
    db   = 0;
  endtask

  // One clock of the event log: pick a grant, move records, then update holds.
  task automatic mstep();
    int g;
    int nd;
    bit pop;
    g   = -1;
    nd  = 0;
    pop = (mq.size() != 0) && out_ready;
    if (mq.size() < DEP)
      for (int k = 0; k < NS; k++)
        if (g < 0 && m_hv[(m_rr + k) % NS]) g = (m_rr + k) % NS;
    if (pop) m_last = mq.pop_front();
    if (g >= 0) begin
      mq.push_back('{ts: m_hts[g], src: g, pl: m_hpl[g]});
      m_rr = (g + 1) % NS;
    end
    for (int i = 0; i < NS; i++) begin
      if (src_valid[i]) begin
        if (!m_hv[i] || g == i) begin
          m_hv[i]  = 1'b1;
          m_hts[i] = m_ts;
          m_hpl[i] = src_payload[i*PW +: PW];
        end else begin
          nd++;
        end
      end else if (g == i) begin
        m_hv[i] = 1'b0;
      end
    end
    if (clear_drops) begin
      da = 0;
      db = 0;
    end else begin
      da = (da + nd > 65535) ? 65535 : da + nd;
      db = (db + nd > 3) ? 3 : db + nd;
    end
    m_ts = m_ts + 32'd1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mreset();
    else mstep();
  end

  always @(negedge clk) begin : cmp
    rec_t e;
    if (rst_n) begin
      if (mq.size() != 0) e = mq[0];
      else e = m_last;
      check("cmp_a_valid", a_valid, mq.size() != 0);
      check("cmp_b_valid", b_valid, mq.size() != 0);
      check("cmp_a_fill", a_fill, mq.size());
      check("cmp_b_fill", b_fill, mq.size());
      check("cmp_a_drop", a_drop, da);
      check("cmp_b_drop", b_drop, db);
      check("cmp_a_ts", a_ts, e.ts);
      check("cmp_b_ts", b_ts, e.ts[3:0]);
      check("cmp_a_src", a_src, e.src);
      check("cmp_b_src", b_src, e.src);
      check("cmp_a_pl", a_pl, e.pl);
      check("cmp_b_pl", b_pl, e.pl);
      if (a_valid && out_ready) popped.push_back('{ts: a_ts, src: int'(a_src), pl: a_pl});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  function automatic logic [NS*PW-1:0] pl1(input int s, input logic [63:0] p);
    logic [NS*PW-1:0] r;
    r = '0;
    r[s*PW +: PW] = p;
    return r;
  endfunction

  task automatic idle_inputs();
    src_valid   = '0;
    src_payload = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_a_valid", a_valid, 1'b0);
    check("rst_mid_a_fill", a_fill, 5'd0);
    check("rst_mid_b_valid", b_valid, 1'b0);
    check("rst_mid_b_fill", b_fill, 5'd0);
    check("rst_mid_a_pl", a_pl, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    popped.delete();
    tick(1);
  endtask

  initial begin
    logic [31:0] t0;
    idle_inputs();
    out_ready   = 1'b1;
    clear_drops = 1'b0;
    mreset();
    #12;
    check("rst_a_valid", a_valid, 1'b0);
    check("rst_a_fill", a_fill, 5'd0);
    check("rst_a_drop", a_drop, 16'd0);
    check("rst_a_ts", a_ts, 32'd0);
    check("rst_a_src", a_src, 2'd0);
    check("rst_a_pl", a_pl, 64'd0);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_b_drop", b_drop, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single event captured at ts=5
    tick(5);
    src_valid   = 4'b0001;
    src_payload = pl1(0, 64'hA5);
    tick(1);
    idle_inputs();
    check("single_t1_valid", a_valid, 1'b0);
    tick(1);
    check("single_t2_valid", a_valid, 1'b1);
    check("single_src", a_src, 2'd0);
    check("single_pl", a_pl, 64'hA5);
    check("single_ts", a_ts, 32'd5);
    check("single_b_ts", b_ts, 4'd5);
    tick(3);

    // round-robin from a fresh pointer
    do_reset();
    src_valid = 4'b1111;
    for (int i = 0; i < NS; i++) src_payload[i*PW +: PW] = 64'h10 + 64'(i);
    tick(1);
    idle_inputs();
    tick(8);
    check("rr_count", popped.size(), 4);
    for (int k = 0; k < 4 && k < popped.size(); k++) begin
      check("rr_src", popped[k].src, k);
      check("rr_pl", popped[k].pl, 64'h10 + 64'(k));
    end
    check("rr_drop", a_drop, 16'd0);
    src_valid   = 4'b1001;
    src_payload = pl1(0, 64'h20) | pl1(3, 64'h23);
    tick(1);
    idle_inputs();
    tick(6);
    check("rr_wrap_count", popped.size(), 6);
    if (popped.size() == 6) begin
      check("rr_wrap_first", popped[4].src, 0);
      check("rr_wrap_second", popped[5].src, 3);
    end

    // overflow on one source with the sink stalled
    popped.delete();
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      src_valid   = 4'b0100;
      src_payload = pl1(2, 64'd100 + 64'(k));
      tick(1);
    end
    idle_inputs();
    tick(2);
    check("ovf_fill", a_fill, 5'd16);
    check("ovf_drop", a_drop, 16'd3);
    check("ovf_b_drop", b_drop, 2'd3);
    out_ready = 1'b1;
    tick(25);
    check("ovf_drain_count", popped.size(), 17);
    for (int k = 0; k < 17 && k < popped.size(); k++)
      check("ovf_order", popped[k].pl, 64'd100 + 64'(k));

    // back-to-back on source 1
    popped.delete();
    t0 = m_ts;
    for (int k = 0; k < 8; k++) begin
      src_valid   = 4'b0010;
      src_payload = pl1(1, 64'd200 + 64'(k));
      tick(1);
    end
    idle_inputs();
    tick(6);
    check("b2b_count", popped.size(), 8);
    for (int k = 0; k < 8 && k < popped.size(); k++) begin
      check("b2b_ts", popped[k].ts, t0 + 32'(k));
      check("b2b_pl", popped[k].pl, 64'd200 + 64'(k));
    end
    check("b2b_drop", a_drop, 16'd3);

    // random backpressure and traffic; narrow timestamps wrap throughout
    for (int k = 0; k < 80; k++) begin
      src_valid = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      for (int i = 0; i < NS; i++) src_payload[i*PW +: PW] = {$urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    idle_inputs();
    out_ready = 1'b1;
    tick(30);
    check("rnd_a_empty", a_fill, 5'd0);
    check("rnd_b_empty", b_fill, 5'd0);

    // drop saturation, clear priority, async reset mid-stream
    clear_drops = 1'b1;
    tick(1);
    clear_drops = 1'b0;
    check("clr_a_drop", a_drop, 16'd0);
    check("clr_b_drop", b_drop, 2'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 17; k++) begin
      src_valid   = 4'b1000;
      src_payload = pl1(3, 64'd300 + 64'(k));
      tick(1);
    end
    idle_inputs();
    tick(1);
    check("sat_fill", a_fill, 5'd16);
    check("sat_pre_drop", a_drop, 16'd0);
    src_valid = 4'b0011;
    src_payload = pl1(0, 64'h400) | pl1(1, 64'h401);
    tick(1);
    src_valid = 4'b1011;
    tick(1);
    src_valid = 4'b0011;
    tick(1);
    idle_inputs();
    check("sat_a_drop", a_drop, 16'd5);
    check("sat_b_drop", b_drop, 2'd3);
    clear_drops = 1'b1;
    src_valid   = 4'b1000;
    tick(1);
    clear_drops = 1'b0;
    idle_inputs();
    check("clr_prio_a", a_drop, 16'd0);
    check("clr_prio_b", b_drop, 2'd0);
    out_ready = 1'b1;
    tick(3);
    do_reset();
    tick(3);
    check("post_rst_valid", a_valid, 1'b0);
    check("post_rst_fill", a_fill, 5'd0);
    check("post_rst_drop", a_drop, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trace_event_collector.md
Name: trace_event_collector

Overview:
Synthesizable front end for the simulation event log. Captures fire-and-forget trace events (read request, read complete, write request, thread status) from NUM_SRC datapath sources and timestamps each on arrival. Events are arbitrated round-robin into a FIFO and presented on a valid/ready stream to the log sink, which formats them as one JSON record per event. Sources are never stalled: overflow drops the event and counts the drop.

Parameters:
NUM_SRC, 4, number of event sources (2..8)
PAYLOAD_W, 64, event payload width (thread_id/address/data packed by the source)
TS_W, 32, timestamp counter width
DEPTH, 16, FIFO entries (power of 2, at least 2)
DROP_W, 16, drop counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
src_valid  in  NUM_SRC  per-source event strobe, one cycle per event
src_payload  in  NUM_SRC*PAYLOAD_W  per-source payload; source i occupies bits [i*PAYLOAD_W +: PAYLOAD_W]
out_valid  out  1  head record available
out_ready  in  1  sink accepts head record
out_ts  out  TS_W  timestamp of head record
out_src  out  $clog2(NUM_SRC)  source index of head record
out_payload  out  PAYLOAD_W  payload of head record
fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy
drop_count  out  DROP_W  saturating count of dropped events
clear_drops  in  1  synchronous clear of drop_count

Behaviour:
- Reset: ts_cnt=0, all hold_v=0, rr_ptr=0, FIFO empty, out_valid=0, out_ts/out_src/out_payload=0, fill_level=0, drop_count=0.
- ts_cnt increments every cycle and wraps modulo 2^TS_W with no flag.
- Per-source hold register (payload, ts, hold_v):
  - src_valid[i] with hold_v[i]=0 captures payload and the current ts_cnt, then sets hold_v[i].
  - src_valid[i] with hold_v[i]=1 and source i granted this cycle captures the new event; hold_v stays 1.
  - src_valid[i] with hold_v[i]=1 and not granted drops the event.
- Drops: drop_count += number of sources dropping this cycle (0..NUM_SRC), saturating at 2^DROP_W-1.
  - clear_drops forces 0. Drops in the same cycle are lost, because clear has priority.
- Arbiter:
  - Grants when fill_level<DEPTH; a same-cycle pop does not free space.
  - Scans hold_v starting at rr_ptr and grants the first set source.
  - On grant, rr_ptr <= (grant+1) mod NUM_SRC. With no grant, rr_ptr holds.
  - At most one grant per cycle.
- Latency: an event strobed in cycle t is in its hold register after edge t. It can be granted in cycle t+1 and written to the FIFO at that edge. Earliest out_valid is cycle t+2.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - out_valid = (fill_level!=0). out_* are driven from the head entry and stay stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready. Push on grant. Simultaneous push and pop leaves fill_level unchanged.
  - out_* hold their last value when empty.
- Ordering:
  - Per source, FIFO order equals arrival order.
  - Across sources, order follows grant order; timestamps may be non-monotonic by up to NUM_SRC cycles.
- Reset mid-operation: all held and queued events are discarded immediately (asynchronous); no partial record is emitted.

Decomposition:
- Shared package trace_pkg holds:
  - trace_src_t enum: SRC_READ_REQ=0, SRC_READ_CMP=1, SRC_WRITE_REQ=2, SRC_THREAD=3.
  - trace_record_t struct: ts, src, payload.
  - Default widths.
- Sub-module trace_fifo: parameterised synchronous FIFO of trace_record_t with push, pop, full, empty and count. The top level owns capture, arbitration, timestamp and drop logic.

Test Plan:
- Single event: reset; src_valid=4'b0001, payload=64'hA5 at ts=5 -> one record out_src=0, out_payload=64'hA5, out_ts=5; out_valid rises 2 cycles after the strobe.
- Round-robin: all four sources strobe in one cycle, out_ready=1 -> records emitted with out_src 0,1,2,3 in order; rr_ptr returns to 0; drop_count=0.
- Overflow: out_ready=0, source 2 strobes every cycle for 20 cycles -> fill_level saturates at 16, hold register full, drop_count=3; after out_ready=1 exactly 17 records drain, in arrival order.
- Back-to-back single source: source 1 strobes 8 consecutive cycles with out_ready=1 -> 8 records, no drops, timestamps strictly increasing by 1.
- Backpressure and counter wrap: TS_W=4, toggle out_ready randomly -> out_* stable while stalled; timestamps wrap 15->0; no duplicated or lost records.
- Drop saturation and clear: DROP_W=2, force 5 drops -> drop_count=3; pulse clear_drops -> 0 the next cycle; assert rst_n low mid-stream -> out_valid=0 and fill_level=0 immediately.
